key_sched_ctrl: RTL and testbench

//  Sequencer for the 128-bit BORON/RECTANGLE key-update datapath. Accepts a start request,

---
 rtl/key_sched_if.sv | 29 ++
 rtl/key_sched_ctrl.sv | 102 ++++++++++
 tb/tb_key_sched_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_sched_if.sv
// Handshake and datapath-control bundle between the key-schedule sequencer,
// its start requester, the key-update datapath and the round-key consumer.
interface key_sched_if #(
    parameter int IDX_W = 5
);
    logic             start;
    logic             start_ready;
    logic             abort;
    logic             ks_load;
    logic             ks_step;
    logic [IDX_W-1:0] ks_rc;
    logic [63:0]      ks_ki;
    logic             rk_valid;
    logic             rk_ready;
    logic [63:0]      rk_data;
    logic [IDX_W-1:0] rk_idx;
    logic             busy;
    logic             done;

    modport master (
        input  start, abort, ks_ki, rk_ready,
        output start_ready, ks_load, ks_step, ks_rc, rk_valid, rk_data, rk_idx, busy, done
    );

    modport slave (
        output start, abort, ks_ki, rk_ready,
        input  start_ready, ks_load, ks_step, ks_rc, rk_valid, rk_data, rk_idx, busy, done
    );
endinterface

// File: rtl/key_sched_ctrl.sv
// Sequencer for the 128-bit key-update datapath: loads the master key, steps it once
// per accepted round key and streams K0..K[ROUNDS] over a valid/ready handshake.
module key_sched_ctrl #(
    parameter int ROUNDS = 25,
    parameter int IDX_W  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    key_sched_if.master ks
);

    if ((2 ** IDX_W) <= ROUNDS) begin : g_bad_idx_w
        $error("IDX_W too narrow to hold round index ROUNDS");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic start_ready;
    logic ks_load;
    logic ks_step;
    logic rk_valid;
    logic done;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        start_ready = 1'b0;
        ks_load     = 1'b0;
        ks_step     = 1'b0;
        rk_valid    = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                start_ready = !ks.abort;
                if (ks.start && !ks.abort) begin
                    ks_load = 1'b1;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                rk_valid = !ks.abort;
                if (rk_valid && ks.rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // Clearing here keeps ks_rc/rk_idx at zero in DONE and IDLE.
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        ks_step = 1'b1;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done    = !ks.abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the state decoded above.
        if (ks.abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    assign ks.start_ready = start_ready;
    assign ks.ks_load     = ks_load;
    assign ks.ks_step     = ks_step;
    assign ks.ks_rc       = idx_q;
    assign ks.rk_valid    = rk_valid;
    assign ks.rk_data     = ks.ks_ki;
    assign ks.rk_idx      = idx_q;
    assign ks.busy        = (state_q != IDLE);
    assign ks.done        = done;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Scoreboard bench for key_sched_ctrl: a behavioural key-update datapath feeds ks_ki,
// and the round keys expected from a golden schedule are queued on start acceptance.
module tb_key_sched_ctrl;
    localparam int ROUNDS = 25;
    localparam int IDX_W  = 5;

    logic clk = 1'b0;
    logic rst_n;

    key_sched_if #(.IDX_W(IDX_W)) bus ();

    key_sched_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (bus)
    );

    always #5 clk = ~clk;

    logic [127:0] master_key;
    logic [127:0] dp_key;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt, step_cnt, done_cnt;

    logic [63:0]      exp_data[$];
    logic [IDX_W-1:0] exp_idx[$];

    logic             prev_stall;
    logic [63:0]      prev_data;
    logic [IDX_W-1:0] prev_idx;

    function automatic logic [63:0] extract(input logic [127:0] k);
        return {k[111:96], k[79:64], k[47:32], k[15:0]};
    endfunction

    // Stand-in key update: rotate left by 13, inject the round constant, mix halves.
    function automatic logic [127:0] rect_update(input logic [127:0] k, input logic [IDX_W-1:0] rc);
        logic [127:0] r;
        r = {k[114:0], k[127:115]} ^ {{(128-IDX_W){1'b0}}, rc};
        r[127:96] = r[127:96] ^ r[63:32];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.ks_load)      dp_key <= master_key;
        else if (bus.ks_step) dp_key <= rect_update(dp_key, bus.ks_rc);
    end

    assign bus.ks_ki = extract(dp_key);

    task automatic push_schedule(input logic [127:0] key);
        logic [127:0] k;
        k = key;
        for (int i = 0; i <= ROUNDS; i++) begin
            exp_data.push_back(extract(k));
            exp_idx.push_back(IDX_W'(i));
            if (i < ROUNDS) k = rect_update(k, IDX_W'(i));
        end
    endtask

    task automatic clear_counts();
        xfer_cnt   = 0;
        step_cnt   = 0;
        done_cnt   = 0;
        prev_stall = 1'b0;
    endtask

    task automatic flush_scoreboard();
        exp_data.delete();
        exp_idx.delete();
        prev_stall = 1'b0;
    endtask

    task automatic sample_cycle(input bit exp_accept);
        logic [63:0]      ed;
        logic [IDX_W-1:0] ei;
        #1;
        n_checks++;
        if (bus.ks_load && bus.ks_step) begin
            n_fail++;
            $display("FAIL load_step_excl: got ks_load=%b ks_step=%b, expected not both 1", bus.ks_load, bus.ks_step);
        end
        if (exp_accept) begin
            n_checks++;
            if (bus.start_ready !== 1'b1 || bus.ks_load !== 1'b1) begin
                n_fail++;
                $display("FAIL start_accept: got start_ready=%b ks_load=%b, expected 1/1", bus.start_ready, bus.ks_load);
            end
            push_schedule(master_key);
        end else if (bus.start) begin
            n_checks++;
            if (bus.ks_load !== 1'b0) begin
                n_fail++;
                $display("FAIL start_ignored: got ks_load=%b, expected 0", bus.ks_load);
            end
        end
        if (bus.abort) begin
            n_checks++;
            if (bus.rk_valid !== 1'b0 || bus.ks_step !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_cycle: got rk_valid=%b ks_step=%b, expected 0/0", bus.rk_valid, bus.ks_step);
            end
            flush_scoreboard();
        end
        if (prev_stall && !bus.abort) begin
            n_checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_data !== prev_data || bus.rk_idx !== prev_idx) begin
                n_fail++;
                $display("FAIL stall_stable: got valid=%b data=%h idx=%0d, expected valid=1 data=%h idx=%0d",
                         bus.rk_valid, bus.rk_data, bus.rk_idx, prev_data, prev_idx);
            end
        end
        if (bus.rk_valid === 1'b1 && bus.rk_ready === 1'b1) begin
            xfer_cnt++;
            n_checks++;
            if (exp_data.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_key: got idx=%0d data=%h, expected no transfer", bus.rk_idx, bus.rk_data);
            end else begin
                ed = exp_data.pop_front();
                ei = exp_idx.pop_front();
                if (bus.rk_data !== ed || bus.rk_idx !== ei) begin
                    n_fail++;
                    $display("FAIL rk_key: got idx=%0d data=%h, expected idx=%0d data=%h", bus.rk_idx, bus.rk_data, ei, ed);
                end
                n_checks++;
                if (bus.ks_step !== (ei < ROUNDS) || (ei < ROUNDS && bus.ks_rc !== ei)) begin
                    n_fail++;
                    $display("FAIL ks_step_rc: got ks_step=%b ks_rc=%0d, expected ks_step=%b ks_rc=%0d",
                             bus.ks_step, bus.ks_rc, (ei < ROUNDS), ei);
                end
            end
        end else begin
            n_checks++;
            if (bus.ks_step !== 1'b0) begin
                n_fail++;
                $display("FAIL step_without_xfer: got ks_step=%b, expected 0", bus.ks_step);
            end
        end
        if (bus.ks_step === 1'b1) step_cnt++;
        if (bus.done === 1'b1)    done_cnt++;
        prev_stall = (bus.rk_valid === 1'b1) && (bus.rk_ready === 1'b0);
        prev_data  = bus.rk_data;
        prev_idx   = bus.rk_idx;
    endtask

    task automatic cycle(input logic st, input logic rdy, input logic ab, input bit exp_accept);
        @(negedge clk);
        bus.start    = st;
        bus.rk_ready = rdy;
        bus.abort    = ab;
        sample_cycle(exp_accept);
    endtask

    // mode 0: rk_ready held high; mode 1: rk_ready toggles 1/0.
    task automatic run_to_done(input int mode, input int max_cycles, output int n);
        n = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            cycle(1'b0, (mode == 0) ? 1'b1 : logic'(i % 2), 1'b0, 1'b0);
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
        n_checks++;
        if (n < 0) begin
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", max_cycles);
        end
    endtask

    task automatic check_counts(input string name, input int xfers, input int steps, input int dones);
        n_checks++;
        if (xfer_cnt != xfers || step_cnt != steps || done_cnt != dones || exp_data.size() != 0) begin
            n_fail++;
            $display("FAIL %s_counts: got xfer=%0d step=%0d done=%0d left=%0d, expected %0d/%0d/%0d/0",
                     name, xfer_cnt, step_cnt, done_cnt, exp_data.size(), xfers, steps, dones);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rk_valid !== 1'b0 ||
            bus.ks_load !== 1'b0 || bus.ks_step !== 1'b0 || bus.ks_rc !== '0 || bus.rk_idx !== '0) begin
            n_fail++;
            $display("FAIL %s: got sr=%b busy=%b done=%b vld=%b load=%b step=%b rc=%0d idx=%0d, expected 1/0/0/0/0/0/0/0",
                     name, bus.start_ready, bus.busy, bus.done, bus.rk_valid, bus.ks_load, bus.ks_step, bus.ks_rc, bus.rk_idx);
        end
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.rk_ready = 1'b0;
        master_key   = '0;
        rst_n        = 1'b0;
        #1;
        check_idle_outputs("reset_asserted");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle_outputs("reset_released");
    endtask

    task automatic test_full_rate(input logic [127:0] key);
        int n;
        clear_counts();
        master_key = key;
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.rk_data !== {key[111:96], key[79:64], key[47:32], key[15:0]} || bus.rk_idx !== '0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL k0: got data=%h idx=%0d busy=%b, expected data=%h idx=0 busy=1",
                     bus.rk_data, bus.rk_idx, bus.busy, {key[111:96], key[79:64], key[47:32], key[15:0]});
        end
        run_to_done(0, 60, n);
        n_checks++;
        if (n + 1 != ROUNDS + 2) begin
            n_fail++;
            $display("FAIL done_latency: got %0d cycles after start, expected %0d", n + 1, ROUNDS + 2);
        end
        check_counts("full_rate", ROUNDS + 1, ROUNDS, 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_idle_outputs("after_done");
    endtask

    task automatic test_backpressure();
        int n;
        clear_counts();
        master_key = {$urandom, $urandom, $urandom, $urandom};
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        run_to_done(1, 200, n);
        n_checks++;
        if (n != 2 * (ROUNDS + 1)) begin
            n_fail++;
            $display("FAIL bp_latency: got done at %0d, expected %0d", n, 2 * (ROUNDS + 1));
        end
        check_counts("backpressure", ROUNDS + 1, ROUNDS, 1);
    endtask

    task automatic test_abort();
        int n;
        clear_counts();
        master_key = {$urandom, $urandom, $urandom, $urandom};
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.rk_valid !== 1'b1 || bus.rk_idx !== IDX_W'(10)) begin
            n_fail++;
            $display("FAIL abort_pre_idx: got valid=%b idx=%0d, expected 1/10", bus.rk_valid, bus.rk_idx);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_idle_outputs("after_abort");
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.start_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_blocks_start: got start_ready=%b, expected 0", bus.start_ready);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.busy !== 1'b0 || done_cnt != 0 || xfer_cnt != 10 || step_cnt != 10) begin
            n_fail++;
            $display("FAIL abort_quiet: got busy=%b done=%0d xfer=%0d step=%0d, expected 0/0/10/10",
                     bus.busy, done_cnt, xfer_cnt, step_cnt);
        end
        clear_counts();
        master_key = {$urandom, $urandom, $urandom, $urandom};
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        run_to_done(0, 60, n);
        check_counts("restart", ROUNDS + 1, ROUNDS, 1);
    endtask

    task automatic test_start_while_busy();
        int n;
        clear_counts();
        master_key = {$urandom, $urandom, $urandom, $urandom};
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        master_key = ~master_key;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.start_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start: got busy=%b start_ready=%b, expected 1/0", bus.busy, bus.start_ready);
        end
        run_to_done(0, 60, n);
        n_checks++;
        if (n != ROUNDS + 2 - 7 + 1) begin
            n_fail++;
            $display("FAIL busy_latency: got done at %0d, expected %0d", n, ROUNDS + 2 - 6);
        end
        check_counts("start_busy", ROUNDS + 1, ROUNDS, 1);
    endtask

    task automatic test_reset_mid();
        clear_counts();
        master_key = {$urandom, $urandom, $urandom, $urandom};
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (bus.rk_idx !== IDX_W'(17) || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_idx: got idx=%0d busy=%b, expected 17/1", bus.rk_idx, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        flush_scoreboard();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle_outputs("reset_mid_release");
    endtask

    task automatic test_start_held();
        clear_counts();
        master_key = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 2 * (ROUNDS + 3); i++) begin
            cycle(1'b1, 1'b1, 1'b0, (i % (ROUNDS + 3)) == 0);
            n_checks++;
            if (bus.done !== ((i % (ROUNDS + 3)) == ROUNDS + 2)) begin
                n_fail++;
                $display("FAIL held_done: cycle %0d got done=%b, expected %b", i, bus.done, ((i % (ROUNDS + 3)) == ROUNDS + 2));
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_counts("start_held", 2 * (ROUNDS + 1), 2 * ROUNDS, 2);
    endtask

    initial begin
        test_reset();
        test_full_rate('0);
        test_full_rate({$urandom, $urandom, $urandom, $urandom});
        test_backpressure();
        test_abort();
        test_start_while_busy();
        test_reset_mid();
        test_full_rate({$urandom, $urandom, $urandom, $urandom});
        test_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
